// File: rtl/uart_tx_core.sv
// uart_tx_core: 8E1/8O1 UART transmitter (start, 8 data LSB-first, parity, stop)
// with a one-entry holding register so back-to-back frames leave no idle gap.
module uart_tx_core #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_out,
  output logic       tx_busy,
  output logic [3:0] bit_count,
  output logic       frame_done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PEN = CW'(CLKS_PER_BIT - 2);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4;
  logic [2:0] state;
  logic [CW-1:0] cnt;
  logic [7:0] hold, shift;
  logic hold_full, par, last, load;
  assign last = cnt == LAST;
  assign load = hold_full && (state == IDLE || (state == STOP && last));
  assign tx_ready = ~hold_full;
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      hold <= '0;
      shift <= '0;
      hold_full <= 1'b0;
      par <= 1'b0;
      tx_out <= 1'b1;
      tx_busy <= 1'b0;
      bit_count <= '0;
      frame_done <= 1'b0;
    end else begin
      // registered so the pulse lands exactly on the last stop-bit cycle
      frame_done <= state == STOP && cnt == PEN;
      cnt <= (state == IDLE || last) ? '0 : cnt + 1'b1;
      if (tx_valid && !hold_full) begin
        hold <= tx_data;
        hold_full <= 1'b1;
      end
      if (load) begin
        shift <= hold;
        par <= ^hold ^ (PARITY_ODD != 0);
        hold_full <= 1'b0;
        state <= START;
        tx_out <= 1'b0;
        tx_busy <= 1'b1;
      end else if (last) begin
        case (state)
          START: begin
            state <= DATA;
            tx_out <= shift[0];
          end
          DATA: begin
            shift <= shift >> 1;
            bit_count <= bit_count == 4'd7 ? 4'd0 : bit_count + 4'd1;
            state <= bit_count == 4'd7 ? PARITY : DATA;
            tx_out <= bit_count == 4'd7 ? par : shift[1];
          end
          PARITY: begin
            state <= STOP;
            tx_out <= 1'b1;
          end
          STOP: begin
            state <= IDLE;
            tx_busy <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: three configurations (C=16 even, C=16 odd, C=2 even) driven
// with directed and random bytes; a per-cycle frame model scores the serial line.
module tb_uart_tx_core;
  typedef struct {logic [7:0] d; int s;} fr_t;
  logic clock = 0;
  int cyc = 0, n_chk = 0, n_fail = 0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input int k, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s inst%0d cycle %0d: got %0d, expected %0d", nm, k, cyc, act, exp);
    end
  endtask

  // Frame bit i of byte d: 0 start, 1..8 data LSB-first, 9 parity, 10 stop.
  function automatic logic fbit(input logic [7:0] d, input int i, input int odd);
    if (i == 0) return 1'b0;
    if (i <= 8) return d[i-1];
    if (i == 9) return (($countones(d) + odd) % 2) == 1;
    return 1'b1;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int C = g == 2 ? 2 : 16;
    localparam int ODD = g == 1 ? 1 : 0;
    logic reset = 0, tx_valid = 0;
    logic [7:0] tx_data = 0;
    logic tx_ready, tx_out, tx_busy, frame_done;
    logic [3:0] bit_count;
    fr_t q[$];
    fr_t cur;
    bit infr = 0, exp_ready = 1, fin = 0;
    logic rprev = 0;
    int last_start = -100000, last_end = -100000, o, b;

    uart_tx_core #(.CLKS_PER_BIT(C), .PARITY_ODD(ODD)) dut (
      .clock(clock), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(tx_ready), .tx_out(tx_out), .tx_busy(tx_busy),
      .bit_count(bit_count), .frame_done(frame_done)
    );

    // Model: a byte accepted at cycle t starts at max(t+2, end of previous frame + 1);
    // the holding register is free again from the cycle that frame starts.
    task automatic drive(input logic r, input logic v, input logic [7:0] d, output bit acc);
      int s;
      reset = r;
      tx_valid = v;
      tx_data = d;
      exp_ready = cyc >= last_start;
      acc = r && v && exp_ready;
      if (acc) begin
        s = cyc + 2 > last_end + 1 ? cyc + 2 : last_end + 1;
        q.push_back('{d, s});
        last_start = s;
        last_end = s + 11 * C - 1;
      end
      if (!r) begin
        last_start = -100000;
        last_end = -100000;
      end
      @(posedge clock);
      #1;
    endtask

    task automatic idle(input int n);
      bit a;
      repeat (n) drive(1, 0, 8'h00, a);
    endtask

    task automatic send(input logic [7:0] d);
      bit a = 0;
      for (int i = 0; i < 20 * C && !a; i++) drive(1, 1, d, a);
    endtask

    initial begin
      bit a;
      int s;
      repeat (3) drive(0, 1, 8'hFF, a);
      idle(4);
      send(8'hA5); idle(11 * C + 4);
      send(8'h07); idle(11 * C + 4);
      send(8'h55); idle(3 * C); send(8'h3C);
      repeat (5) drive(1, 1, 8'h99, a);
      idle(24 * C);
      send(8'hFF); s = last_start; send(8'h12);
      while (cyc < s + 5 * C + C / 2) idle(1);
      repeat (2) drive(0, 0, 8'h00, a);
      idle(4);
      send(8'h00); idle(11 * C + 4);
      send(8'h81); idle(11 * C + 4);
      repeat (30) begin
        send(8'($urandom));
        if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 13 * C));
      end
      idle(24 * C + 4);
      chk("leftover", g, q.size() + int'(infr), 0);
      fin = 1;
    end

    always @(negedge clock) begin
      if (!rprev) begin
        q.delete();
        infr = 0;
        chk("rst_out", g, int'(tx_out), 1);
        chk("rst_ready", g, int'(tx_ready), 1);
        chk("rst_busy", g, int'(tx_busy), 0);
        chk("rst_bc", g, int'(bit_count), 0);
        chk("rst_fd", g, int'(frame_done), 0);
      end else begin
        if (!infr && q.size() > 0 && q[0].s == cyc) begin
          cur = q.pop_front();
          infr = 1;
        end
        if (infr) begin
          o = cyc - cur.s;
          b = o / C;
          chk("tx_out", g, int'(tx_out), int'(fbit(cur.d, b, ODD)));
          chk("busy", g, int'(tx_busy), 1);
          chk("bit_count", g, int'(bit_count), (b >= 1 && b <= 8) ? b - 1 : 0);
          chk("frame_done", g, int'(frame_done), int'(o == 11 * C - 1));
          if (o == 11 * C - 1) infr = 0;
        end else begin
          chk("idle_out", g, int'(tx_out), 1);
          chk("idle_busy", g, int'(tx_busy), 0);
          chk("idle_bc", g, int'(bit_count), 0);
          chk("idle_fd", g, int'(frame_done), 0);
        end
        chk("ready", g, int'(tx_ready), int'(exp_ready));
      end
      rprev = reset;
    end
  end

  initial begin
    for (int i = 0; i < 90000 && !(u[0].fin && u[1].fin && u[2].fin); i++) @(posedge clock);
    chk("finished", 0, int'(u[0].fin && u[1].fin && u[2].fin), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
